// File: rtl/ctrl_sig_pkg.sv
// rtl/ctrl_sig_pkg.sv - shared control-field encodings and opcodes for main_decode
// Contents: ALU category/op codes, PC modes, LSU widths, RV32 major opcodes,
//           the registered decode bundle type and the ALU op selector.
package ctrl_sig_pkg;

    // ALU categories (CtrlALUOp[3:2])
    localparam logic [1:0] ALUBT = 2'b00;
    localparam logic [1:0] ALUAS = 2'b01;
    localparam logic [1:0] ALUSH = 2'b10;
    localparam logic [1:0] ALUFL = 2'b11;

    // Bitwise ops
    localparam logic [1:0] BTNOP = 2'b00;
    localparam logic [1:0] BTXOR = 2'b01;
    localparam logic [1:0] BTOR  = 2'b10;
    localparam logic [1:0] BTAND = 2'b11;

    // Add/sub ops
    localparam logic [1:0] AFSUBS = 2'b00;
    localparam logic [1:0] AFADDS = 2'b01;

    // Flag ops
    localparam logic [1:0] FLSLT  = 2'b00;
    localparam logic [1:0] FLSLTU = 2'b10;
    localparam logic [1:0] FLEQ   = 2'b11;

    // Shift ops
    localparam logic [1:0] SHSLL = 2'b00;
    localparam logic [1:0] SHSRL = 2'b10;
    localparam logic [1:0] SHSRA = 2'b11;

    // PC modes
    localparam logic [1:0] PCINC  = 2'b00;
    localparam logic [1:0] PCBRA  = 2'b01;
    localparam logic [1:0] PCJREG = 2'b10;
    localparam logic [1:0] PCJIMM = 2'b11;

    // LSU widths
    localparam logic [1:0] LSN = 2'b00;
    localparam logic [1:0] LSW = 2'b01;
    localparam logic [1:0] LSH = 2'b10;
    localparam logic [1:0] LSB = 2'b11;

    // RV32 major opcodes
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm_alu;
        logic [31:0] imm_pc;
        logic [3:0]  ctrl_lsu;
        logic        multi_cycle;
        logic        alu_imm;
        logic [3:0]  alu_op;
        logic        flag_inv;
        logic        pc_writeback;
        logic [1:0]  pc_mode;
        logic        valid;
    } decode_t;

    localparam decode_t DECODE_NOP = '0;

    // OP/OP-IMM funct3 to ALU op; alt selects SUB/SRA
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? {ALUAS, AFSUBS} : {ALUAS, AFADDS};
            3'b001:  op = {ALUSH, SHSLL};
            3'b010:  op = {ALUFL, FLSLT};
            3'b011:  op = {ALUFL, FLSLTU};
            3'b100:  op = {ALUBT, BTXOR};
            3'b101:  op = alt ? {ALUSH, SHSRA} : {ALUSH, SHSRL};
            3'b110:  op = {ALUBT, BTOR};
            default: op = {ALUBT, BTAND};
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rvc_expand.sv
// rtl/rvc_expand.sv - combinational RVC (16-bit) to RV32 instruction expansion
// Used only when MAIN_DECODE_RVC_EN is defined.
// Ports: instr_i  16-bit compressed word
//        instr_o  32-bit equivalent; all-zero (an illegal RV32 opcode) when reserved/illegal
module rvc_expand
    import ctrl_sig_pkg::*;
(
    input  logic [15:0] instr_i,
    output logic [31:0] instr_o
);

    logic [4:0]  rd_p;
    logic [4:0]  rs1_p;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [11:0] j_off;
    logic        c12;

    assign rd_p  = {2'b01, instr_i[4:2]};
    assign rs1_p = {2'b01, instr_i[9:7]};
    assign rd    = instr_i[11:7];
    assign rs2   = instr_i[6:2];
    assign c12   = instr_i[12];
    // C.J / C.JAL offset, scrambled in the 16-bit encoding
    assign j_off = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                    instr_i[2], instr_i[11], instr_i[5:3], 1'b0};

    always_comb begin
        instr_o = 32'h0;
        case (instr_i[1:0])
            2'b00: begin
                case (instr_i[15:13])
                    3'b000: if (instr_i[12:5] != 8'h0)
                        instr_o = {2'b00, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00,
                                   5'd2, 3'b000, rd_p, OPC_OP_IMM};
                    3'b010: instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00,
                                       rs1_p, 3'b010, rd_p, OPC_LOAD};
                    3'b110: instr_o = {5'b0, instr_i[5], c12, rd_p, rs1_p, 3'b010,
                                       instr_i[11:10], instr_i[6], 2'b00, OPC_STORE};
                    default: ;
                endcase
            end
            2'b01: begin
                case (instr_i[15:13])
                    3'b000: instr_o = {{7{c12}}, instr_i[6:2], rd, 3'b000, rd, OPC_OP_IMM};
                    3'b001: instr_o = {j_off[11], j_off[10:1], j_off[11], {8{j_off[11]}}, 5'd1, OPC_JAL};
                    3'b010: instr_o = {{7{c12}}, instr_i[6:2], 5'd0, 3'b000, rd, OPC_OP_IMM};
                    3'b011: begin
                        if ({c12, instr_i[6:2]} != 6'h0) begin
                            if (rd == 5'd2)
                                instr_o = {{3{c12}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6], 4'b0,
                                           5'd2, 3'b000, 5'd2, OPC_OP_IMM};
                            else
                                instr_o = {{15{c12}}, instr_i[6:2], rd, OPC_LUI};
                        end
                    end
                    3'b100: begin
                        case (instr_i[11:10])
                            2'b00: if (!c12)
                                instr_o = {7'b0000000, instr_i[6:2], rs1_p, 3'b101, rs1_p, OPC_OP_IMM};
                            2'b01: if (!c12)
                                instr_o = {7'b0100000, instr_i[6:2], rs1_p, 3'b101, rs1_p, OPC_OP_IMM};
                            2'b10:
                                instr_o = {{7{c12}}, instr_i[6:2], rs1_p, 3'b111, rs1_p, OPC_OP_IMM};
                            default: if (!c12) begin
                                case (instr_i[6:5])
                                    2'b00:   instr_o = {7'b0100000, rd_p, rs1_p, 3'b000, rs1_p, OPC_OP};
                                    2'b01:   instr_o = {7'b0000000, rd_p, rs1_p, 3'b100, rs1_p, OPC_OP};
                                    2'b10:   instr_o = {7'b0000000, rd_p, rs1_p, 3'b110, rs1_p, OPC_OP};
                                    default: instr_o = {7'b0000000, rd_p, rs1_p, 3'b111, rs1_p, OPC_OP};
                                endcase
                            end
                        endcase
                    end
                    3'b101: instr_o = {j_off[11], j_off[10:1], j_off[11], {8{j_off[11]}}, 5'd0, OPC_JAL};
                    default: // C.BEQZ / C.BNEZ, funct3 picked by bit 13
                        instr_o = {{4{c12}}, instr_i[6:5], instr_i[2], 5'd0, rs1_p, 2'b00, instr_i[13],
                                   instr_i[11:10], instr_i[4:3], c12, OPC_BRANCH};
                endcase
            end
            2'b10: begin
                case (instr_i[15:13])
                    3'b000: if (!c12)
                        instr_o = {7'b0000000, instr_i[6:2], rd, 3'b001, rd, OPC_OP_IMM};
                    3'b010: if (rd != 5'd0)
                        instr_o = {4'b0, instr_i[3:2], c12, instr_i[6:4], 2'b00, 5'd2, 3'b010, rd, OPC_LOAD};
                    3'b100: begin
                        if (rs2 == 5'd0) begin
                            // C.JR / C.JALR; rd=0 is reserved or C.EBREAK (SYSTEM, unsupported)
                            if (rd != 5'd0)
                                instr_o = {12'b0, rd, 3'b000, 4'b0000, c12, OPC_JALR};
                        end else if (!c12) begin
                            instr_o = {7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP};
                        end else begin
                            instr_o = {7'b0000000, rs2, rd, 3'b000, rd, OPC_OP};
                        end
                    end
                    3'b110: instr_o = {4'b0, instr_i[8:7], c12, rs2, 5'd2, 3'b010,
                                       instr_i[11:9], 2'b00, OPC_STORE};
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/main_decode.sv
// rtl/main_decode.sv - registered RV32I/RV32E instruction decoder, one-cycle latency
// Optional feature: MAIN_DECODE_RVC_EN enables 16-bit (RVC) expansion via rvc_expand.
// Parameter: embedded  0 = RV32I, 1 = RV32E (register fields >= 16 are illegal)
// Ports: clk, rst (async active-low), InstructionIn[31:0]
//        Rs1/Rs2/Rd, ImmALU, ImmPC, CtrlLSU, CtrlMultiCycle, CtrlALUImm, CtrlALUOp,
//        CtrlFlagInv, CtrlPCWriteback, CtrlPCMode, ValidDecode, CompressedDecode
module main_decode
    import ctrl_sig_pkg::*;
#(
    parameter bit embedded = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstructionIn,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic [4:0]  Rd,
    output logic [31:0] ImmALU,
    output logic [31:0] ImmPC,
    output logic [3:0]  CtrlLSU,
    output logic        CtrlMultiCycle,
    output logic        CtrlALUImm,
    output logic [3:0]  CtrlALUOp,
    output logic        CtrlFlagInv,
    output logic        CtrlPCWriteback,
    output logic [1:0]  CtrlPCMode,
    output logic        ValidDecode,
    output logic        CompressedDecode
);

    logic [31:0] instr;
    logic        is_comp;

`ifdef MAIN_DECODE_RVC_EN
    logic [31:0] expanded;

    rvc_expand u_rvc_expand (
        .instr_i (InstructionIn[15:0]),
        .instr_o (expanded)
    );

    assign is_comp = (InstructionIn[1:0] != 2'b11);
    assign instr   = is_comp ? expanded : InstructionIn;
`else
    // Without expansion a 16-bit word falls through to an illegal opcode
    assign is_comp = 1'b0;
    assign instr   = InstructionIn;
`endif

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    decode_t dec_d, dec_q;
    logic    comp_d, comp_q;
    logic    legal;

    always_comb begin
        dec_d = DECODE_NOP;
        legal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_d.rs1     = instr[19:15];
                dec_d.rd      = instr[11:7];
                dec_d.alu_imm = 1'b1;
                dec_d.imm_alu = imm_i;
                dec_d.alu_op  = alu_sel(f3, (f3 == 3'b101) && f7[5]);
                legal         = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec_d.imm_alu = {27'b0, instr[24:20]};
                    legal = (f7 == 7'b0000000) || (f3 == 3'b101 && f7 == 7'b0100000);
                end
            end
            OPC_OP: begin
                dec_d.rs1    = instr[19:15];
                dec_d.rs2    = instr[24:20];
                dec_d.rd     = instr[11:7];
                dec_d.alu_op = alu_sel(f3, f7[5]);
                legal = (f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_LUI: begin
                dec_d.rd      = instr[11:7];
                dec_d.alu_imm = 1'b1;
                dec_d.imm_alu = imm_u;
                dec_d.alu_op  = {ALUAS, AFADDS};
                legal         = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.rd           = instr[11:7];
                dec_d.pc_writeback = 1'b1;
                dec_d.imm_pc       = imm_u;
                legal              = 1'b1;
            end
            OPC_LOAD: begin
                dec_d.rs1         = instr[19:15];
                dec_d.rd          = instr[11:7];
                dec_d.alu_imm     = 1'b1;
                dec_d.imm_alu     = imm_i;
                dec_d.alu_op      = {ALUAS, AFADDS};
                dec_d.multi_cycle = 1'b1;
                legal             = 1'b1;
                case (f3)
                    3'b000:  dec_d.ctrl_lsu = {2'b00, LSB};
                    3'b001:  dec_d.ctrl_lsu = {2'b00, LSH};
                    3'b010:  dec_d.ctrl_lsu = {2'b00, LSW};
                    3'b100:  dec_d.ctrl_lsu = {2'b10, LSB};
                    3'b101:  dec_d.ctrl_lsu = {2'b10, LSH};
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec_d.rs1         = instr[19:15];
                dec_d.rs2         = instr[24:20];
                dec_d.alu_imm     = 1'b1;
                dec_d.imm_alu     = imm_s;
                dec_d.alu_op      = {ALUAS, AFADDS};
                dec_d.multi_cycle = 1'b1;
                legal             = 1'b1;
                case (f3)
                    3'b000:  dec_d.ctrl_lsu = {2'b01, LSB};
                    3'b001:  dec_d.ctrl_lsu = {2'b01, LSH};
                    3'b010:  dec_d.ctrl_lsu = {2'b01, LSW};
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                dec_d.rs1      = instr[19:15];
                dec_d.rs2      = instr[24:20];
                dec_d.pc_mode  = PCBRA;
                dec_d.imm_pc   = imm_b;
                // odd funct3 is the negated form of its even partner
                dec_d.flag_inv = f3[0];
                legal          = 1'b1;
                case (f3[2:1])
                    2'b00:   dec_d.alu_op = {ALUFL, FLEQ};
                    2'b10:   dec_d.alu_op = {ALUFL, FLSLT};
                    2'b11:   dec_d.alu_op = {ALUFL, FLSLTU};
                    default: legal = 1'b0;
                endcase
            end
            OPC_JAL: begin
                dec_d.rd           = instr[11:7];
                dec_d.pc_writeback = 1'b1;
                dec_d.pc_mode      = PCJIMM;
                dec_d.imm_pc       = imm_j;
                legal              = 1'b1;
            end
            OPC_JALR: begin
                dec_d.rs1          = instr[19:15];
                dec_d.rd           = instr[11:7];
                dec_d.pc_writeback = 1'b1;
                dec_d.pc_mode      = PCJREG;
                dec_d.imm_pc       = imm_i;
                legal              = (f3 == 3'b000);
            end
            OPC_MISC_MEM: legal = (f3 == 3'b000);
            default:      legal = 1'b0;
        endcase

        // Unused register fields are left at 0, so only live indices are screened
        if (embedded && (dec_d.rs1[4] || dec_d.rs2[4] || dec_d.rd[4]))
            legal = 1'b0;

        if (legal)
            dec_d.valid = 1'b1;
        else
            dec_d = DECODE_NOP;

        comp_d = dec_d.valid && is_comp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_q  <= DECODE_NOP;
            comp_q <= 1'b0;
        end else begin
            dec_q  <= dec_d;
            comp_q <= comp_d;
        end
    end

    assign Rs1              = dec_q.rs1;
    assign Rs2              = dec_q.rs2;
    assign Rd               = dec_q.rd;
    assign ImmALU           = dec_q.imm_alu;
    assign ImmPC            = dec_q.imm_pc;
    assign CtrlLSU          = dec_q.ctrl_lsu;
    assign CtrlMultiCycle   = dec_q.multi_cycle;
    assign CtrlALUImm       = dec_q.alu_imm;
    assign CtrlALUOp        = dec_q.alu_op;
    assign CtrlFlagInv      = dec_q.flag_inv;
    assign CtrlPCWriteback  = dec_q.pc_writeback;
    assign CtrlPCMode       = dec_q.pc_mode;
    assign ValidDecode      = dec_q.valid;
    assign CompressedDecode = comp_q;

endmodule

// File: tb/tb_main_decode.sv
// tb/tb_main_decode.sv - self-checking bench for main_decode (RV32I and RV32E instances)
module tb_main_decode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] instr;

    logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
    logic [31:0] a_ia, a_ip, b_ia, b_ip;
    logic [3:0]  a_lsu, a_op, b_lsu, b_op;
    logic        a_mc, a_aimm, a_inv, a_wb, a_valid, a_comp;
    logic        b_mc, b_aimm, b_inv, b_wb, b_valid, b_comp;
    logic [1:0]  a_mode, b_mode;

    main_decode u_dut (
        .clk(clk), .rst(rst), .InstructionIn(instr),
        .Rs1(a_rs1), .Rs2(a_rs2), .Rd(a_rd), .ImmALU(a_ia), .ImmPC(a_ip),
        .CtrlLSU(a_lsu), .CtrlMultiCycle(a_mc), .CtrlALUImm(a_aimm), .CtrlALUOp(a_op),
        .CtrlFlagInv(a_inv), .CtrlPCWriteback(a_wb), .CtrlPCMode(a_mode),
        .ValidDecode(a_valid), .CompressedDecode(a_comp)
    );

    main_decode #(.embedded(1'b1)) u_emb (
        .clk(clk), .rst(rst), .InstructionIn(instr),
        .Rs1(b_rs1), .Rs2(b_rs2), .Rd(b_rd), .ImmALU(b_ia), .ImmPC(b_ip),
        .CtrlLSU(b_lsu), .CtrlMultiCycle(b_mc), .CtrlALUImm(b_aimm), .CtrlALUOp(b_op),
        .CtrlFlagInv(b_inv), .CtrlPCWriteback(b_wb), .CtrlPCMode(b_mode),
        .ValidDecode(b_valid), .CompressedDecode(b_comp)
    );

    typedef struct {
        string       tag;
        bit          sel;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] ia, ip;
        logic [3:0]  lsu;
        logic        mc, aimm;
        logic [3:0]  op;
        logic        inv, wb;
        logic [1:0]  mode;
        logic        valid, comp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
        end
    endtask

    function automatic exp_t mk(input string tag, input bit sel,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] ia, input logic [31:0] ip, input logic [3:0] lsu,
                                input logic mc, input logic aimm, input logic [3:0] op,
                                input logic inv, input logic wb, input logic [1:0] mode,
                                input logic valid, input logic comp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ia = ia; e.ip = ip;
        e.lsu = lsu; e.mc = mc; e.aimm = aimm; e.op = op; e.inv = inv; e.wb = wb;
        e.mode = mode; e.valid = valid; e.comp = comp;
        return e;
    endfunction

    function automatic exp_t nop_exp(input string tag, input bit sel);
        return mk(tag, sel, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = q.pop_front();
        if (!e.sel) begin
            chk(e.tag, "rs1", 32'(a_rs1), 32'(e.rs1));   chk(e.tag, "rs2", 32'(a_rs2), 32'(e.rs2));
            chk(e.tag, "rd", 32'(a_rd), 32'(e.rd));      chk(e.tag, "immalu", a_ia, e.ia);
            chk(e.tag, "immpc", a_ip, e.ip);             chk(e.tag, "lsu", 32'(a_lsu), 32'(e.lsu));
            chk(e.tag, "mc", 32'(a_mc), 32'(e.mc));      chk(e.tag, "aluimm", 32'(a_aimm), 32'(e.aimm));
            chk(e.tag, "aluop", 32'(a_op), 32'(e.op));   chk(e.tag, "inv", 32'(a_inv), 32'(e.inv));
            chk(e.tag, "wb", 32'(a_wb), 32'(e.wb));      chk(e.tag, "mode", 32'(a_mode), 32'(e.mode));
            chk(e.tag, "valid", 32'(a_valid), 32'(e.valid)); chk(e.tag, "comp", 32'(a_comp), 32'(e.comp));
        end else begin
            chk(e.tag, "rs1", 32'(b_rs1), 32'(e.rs1));   chk(e.tag, "rs2", 32'(b_rs2), 32'(e.rs2));
            chk(e.tag, "rd", 32'(b_rd), 32'(e.rd));      chk(e.tag, "immalu", b_ia, e.ia);
            chk(e.tag, "immpc", b_ip, e.ip);             chk(e.tag, "lsu", 32'(b_lsu), 32'(e.lsu));
            chk(e.tag, "mc", 32'(b_mc), 32'(e.mc));      chk(e.tag, "aluimm", 32'(b_aimm), 32'(e.aimm));
            chk(e.tag, "aluop", 32'(b_op), 32'(e.op));   chk(e.tag, "inv", 32'(b_inv), 32'(e.inv));
            chk(e.tag, "wb", 32'(b_wb), 32'(e.wb));      chk(e.tag, "mode", 32'(b_mode), 32'(e.mode));
            chk(e.tag, "valid", 32'(b_valid), 32'(e.valid)); chk(e.tag, "comp", 32'(b_comp), 32'(e.comp));
        end
    endtask

    task automatic step(input logic [31:0] w, input exp_t e);
        @(negedge clk);
        instr = w;
        q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        rst   = 1'b0;
        instr = 32'h00500093;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset", "rd", 32'(a_rd), 32'd0);
        chk("reset", "immalu", a_ia, 32'd0);
        chk("reset", "aluop", 32'(a_op), 32'd0);
        chk("reset", "aluimm", 32'(a_aimm), 32'd0);
        chk("reset", "mode", 32'(a_mode), 32'd0);
        chk("reset", "valid", 32'(a_valid), 32'd0);
        chk("reset_e", "valid", 32'(b_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        //          tag       sel rs1 rs2 rd  immalu        immpc         lsu  mc aimm op      inv wb mode   v  c
        step(32'h00500093, mk("addi",  0, 0,  0,  1,  32'd5,        32'd0,        4'h0, 0, 1, 4'b0101, 0, 0, 2'b00, 1, 0));
        step(32'h00209463, mk("bne",   0, 1,  2,  0,  32'd0,        32'd8,        4'h0, 0, 0, 4'b1111, 1, 0, 2'b01, 1, 0));
        step(32'hFFDFF0EF, mk("jal",   0, 0,  0,  1,  32'd0,        32'hFFFFFFFC, 4'h0, 0, 0, 4'b0000, 0, 1, 2'b11, 1, 0));
        step(32'h402081B3, mk("sub",   0, 1,  2,  3,  32'd0,        32'd0,        4'h0, 0, 0, 4'b0100, 0, 0, 2'b00, 1, 0));
        step(32'h40335293, mk("srai",  0, 6,  0,  5,  32'd3,        32'd0,        4'h0, 0, 1, 4'b1011, 0, 0, 2'b00, 1, 0));
        step(32'h02331293, nop_exp("slli_b25", 0));
        step(32'hFFF44383, mk("lbu",   0, 8,  0,  7,  32'hFFFFFFFF, 32'd0,        4'hB, 1, 1, 4'b0101, 0, 0, 2'b00, 1, 0));
        step(32'h00952623, mk("sw",    0, 10, 9,  0,  32'd12,       32'd0,        4'h5, 1, 1, 4'b0101, 0, 0, 2'b00, 1, 0));
        step(32'h12345237, mk("lui",   0, 0,  0,  4,  32'h12345000, 32'd0,        4'h0, 0, 1, 4'b0101, 0, 0, 2'b00, 1, 0));
        step(32'h00001317, mk("auipc", 0, 0,  0,  6,  32'd0,        32'h00001000, 4'h0, 0, 0, 4'b0000, 0, 1, 2'b00, 1, 0));
        step(32'h010100E7, mk("jalr",  0, 2,  0,  1,  32'd0,        32'd16,       4'h0, 0, 0, 4'b0000, 0, 1, 2'b10, 1, 0));
        step(32'hFE41FFE3, mk("bgeu",  0, 3,  4,  0,  32'd0,        32'hFFFFFFFE, 4'h0, 0, 0, 4'b1110, 1, 0, 2'b01, 1, 0));
        step(32'h003130B3, mk("sltu",  0, 2,  3,  1,  32'd0,        32'd0,        4'h0, 0, 0, 4'b1110, 0, 0, 2'b00, 1, 0));
        step(32'h0FF0000F, mk("fence", 0, 0,  0,  0,  32'd0,        32'd0,        4'h0, 0, 0, 4'b0000, 0, 0, 2'b00, 1, 0));
        step(32'h00000073, nop_exp("ecall", 0));
`ifdef MAIN_DECODE_RVC_EN
        step(32'h00000405, mk("c_addi", 0, 8, 0,  8,  32'd1,        32'd0,        4'h0, 0, 1, 4'b0101, 0, 0, 2'b00, 1, 1));
`else
        step(32'h00000405, nop_exp("c_addi", 0));
`endif
        step(32'h00000833, nop_exp("e_add_x16", 1));
        step(32'h003100B3, mk("e_add", 1, 2,  3,  1,  32'd0,        32'd0,        4'h0, 0, 0, 4'b0101, 0, 0, 2'b00, 1, 0));
        step(32'h00000833, mk("i_add_x16", 0, 0, 0, 16, 32'd0,      32'd0,        4'h0, 0, 0, 4'b0101, 0, 0, 2'b00, 1, 0));

        // Mid-stream reset: asynchronous clear, then decode of the word at the first edge after release
        step(32'h00500093, mk("pre_rst", 0, 0, 0, 1, 32'd5, 32'd0, 4'h0, 0, 1, 4'b0101, 0, 0, 2'b00, 1, 0));
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst", "rd", 32'(a_rd), 32'd0);
        chk("async_rst", "immalu", a_ia, 32'd0);
        chk("async_rst", "aluop", 32'(a_op), 32'd0);
        chk("async_rst", "valid", 32'(a_valid), 32'd0);
        instr = 32'h00209463;
        @(posedge clk);
        #1;
        chk("held_rst", "valid", 32'(a_valid), 32'd0);
        chk("held_rst", "rs2", 32'(a_rs2), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        q.push_back(mk("post_rst", 0, 1, 2, 0, 32'd0, 32'd8, 4'h0, 0, 0, 4'b1111, 1, 0, 2'b01, 1, 0));
        @(posedge clk);
        #1;
        check_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
